// File: rtl/seg_pkg.sv
// Shared types and constants for the 3-digit 7-segment scan path.
// Segment constants are active-high, bit order gfedcba.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT_0 = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b0000110;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b1011011;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b1001111;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b1100110;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b1101101;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b1111101;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b0000111;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b1100111;

    // Double-dabble pre-shift correction: every BCD nibble >= 5 gets +3.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD nibble to gfedcba segment decoder.
// Non-decimal nibbles produce a blank digit.
module seg7_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Binary-to-BCD conversion (sequential double dabble) feeding a 3-digit
// time-multiplexed 7-segment scanner that shares one decoder.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        busy,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  digit_en
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    state_t      state, state_next;
    logic [7:0]  shreg;
    logic [11:0] scratch;
    logic [11:0] scratch_adj;
    logic [2:0]  iter;
    logic        accept;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    dec_seg;

    // Handshake: a value transfers on any rising edge where load_valid and
    // load_ready are both high; load_ready is high only in IDLE.
    assign accept      = load_valid & load_ready;
    assign scratch_adj = bcd_adjust(scratch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_valid)    state_next = SHIFT;
            SHIFT:   if (iter == 3'd7)  state_next = COMMIT;
            COMMIT:                     state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            iter    <= '0;
            bcd     <= '0;
        end else if (accept) begin
            shreg   <= load_data;
            scratch <= '0;
            iter    <= '0;
        end else if (state == SHIFT) begin
            scratch <= {scratch_adj[10:0], shreg[7]};
            shreg   <= {shreg[6:0], 1'b0};
            iter    <= iter + 3'd1;
        end else if (state == COMMIT) begin
            bcd     <= scratch;
        end
    end

    // Scanner is free-running and independent of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        nibble = bcd[3:0];
        blank  = 1'b0;
        case (idx)
            2'd1: begin
                nibble = bcd[7:4];
                blank  = BLANK_LEADING && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nibble = bcd[11:8];
                blank  = BLANK_LEADING && (bcd[11:8] == 4'd0);
            end
            default: begin
                nibble = bcd[3:0];
                blank  = 1'b0;
            end
        endcase
    end

    seg7_bcd_decode u_decode (
        .digit (nibble),
        .seg   (dec_seg)
    );

    // seg and digit_en update on the same edge so no digit shows another's pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= SEG_BLANK;
            digit_en <= '0;
        end else begin
            seg <= blank ? SEG_BLANK : dec_seg;
            case (idx)
                2'd1:    digit_en <= 3'b010;
                2'd2:    digit_en <= 3'b100;
                default: digit_en <= 3'b001;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: vector table of loads with
// expected BCD and per-digit segments, plus reset and handshake sequences.
module tb_seg_scan_controller;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  digit_en;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0]  value;
        logic [11:0] exp_bcd;
        logic [6:0]  seg_u;
        logic [6:0]  seg_t;
        logic [6:0]  seg_h;
    } vec_t;

    vec_t vecs[8];

    seg_scan_controller #(
        .SCAN_DIV      (2),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .busy       (busy),
        .bcd        (bcd),
        .seg        (seg),
        .digit_en   (digit_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) check("wait_ready_timeout", 32'(load_ready), 32'd1);
    endtask

    // Drive one value and follow the conversion through to commit.
    task automatic do_load(input logic [7:0] v, input logic [11:0] prev, input logic [11:0] exp);
        int low_cnt;
        bit stable;
        bit busy_ok;
        wait_ready();
        load_valid = 1'b1;
        load_data  = v;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = '0;
        low_cnt = 0;
        stable  = 1'b1;
        busy_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== ~load_ready) busy_ok = 1'b0;
            if (load_ready) break;
            low_cnt++;
            if (bcd !== prev) stable = 1'b0;
        end
        check("ready_low_cycles", 32'(low_cnt), 32'd9);
        check("bcd_held_during_conv", 32'(stable), 32'd1);
        check("busy_is_not_ready", 32'(busy_ok), 32'd1);
        check("bcd_commit", 32'(bcd), 32'(exp));
    endtask

    // Sample a full scan period and compare the segments shown on each digit.
    task automatic observe(input logic [6:0] eu, input logic [6:0] et, input logic [6:0] eh);
        logic [6:0] su, st, sh;
        bit onehot_ok;
        su = 'x;
        st = 'x;
        sh = 'x;
        onehot_ok = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (digit_en)
                3'b001:  su = seg;
                3'b010:  st = seg;
                3'b100:  sh = seg;
                default: onehot_ok = 1'b0;
            endcase
        end
        check("digit_en_onehot", 32'(onehot_ok), 32'd1);
        check("seg_units", 32'(su), 32'(eu));
        check("seg_tens", 32'(st), 32'(et));
        check("seg_hundreds", 32'(sh), 32'(eh));
    endtask

    initial begin
        logic [11:0] prev_bcd;
        logic [2:0]  exp_en[7];
        logic [6:0]  exp_sg[7];

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;

        vecs[0] = '{8'd255, 12'h255, 7'b1101101, 7'b1101101, 7'b1011011};
        vecs[1] = '{8'd42,  12'h042, 7'b1011011, 7'b1100110, 7'b0000000};
        vecs[2] = '{8'd7,   12'h007, 7'b0000111, 7'b0000000, 7'b0000000};
        vecs[3] = '{8'd100, 12'h100, 7'b0111111, 7'b0111111, 7'b0000110};
        vecs[4] = '{8'd0,   12'h000, 7'b0111111, 7'b0000000, 7'b0000000};
        vecs[5] = '{8'd99,  12'h099, 7'b1100111, 7'b1100111, 7'b0000000};
        vecs[6] = '{8'd10,  12'h010, 7'b0111111, 7'b0000110, 7'b0000000};
        vecs[7] = '{8'd128, 12'h128, 7'b1111111, 7'b1011011, 7'b0000110};

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_digit_en", 32'(digit_en), 32'h0);

        // After release: each digit held two cycles, units/tens/hundreds order.
        exp_en = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        exp_sg = '{7'b0111111, 7'b0111111, 7'b0000000, 7'b0000000,
                   7'b0000000, 7'b0000000, 7'b0111111};
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("scan_digit_en_%0d", i), 32'(digit_en), 32'(exp_en[i]));
            check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(exp_sg[i]));
        end

        prev_bcd = 12'h000;
        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].value, prev_bcd, vecs[i].exp_bcd);
            observe(vecs[i].seg_u, vecs[i].seg_t, vecs[i].seg_h);
            prev_bcd = vecs[i].exp_bcd;
        end

        // load_valid held from T2 while busy: accepted only when ready returns.
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'd55;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 8'd200;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("hold_ready_after_t9", 32'(load_ready), 32'd1);
        check("hold_bcd_first", 32'(bcd), 32'h055);
        @(posedge clk);
        #1;
        check("hold_accepted_t10", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        load_data  = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("hold_bcd_before_commit", 32'(bcd), 32'h055);
        @(negedge clk);
        check("hold_bcd_second", 32'(bcd), 32'h200);
        check("hold_ready_again", 32'(load_ready), 32'd1);

        // Reset at T4 of a conversion of 99.
        wait_ready();
        load_valid = 1'b1;
        load_data  = 8'd99;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bcd), 32'h000);
        check("midrst_ready", 32'(load_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_seg", 32'(seg), 32'h00);
        check("midrst_digit_en", 32'(digit_en), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_commit_bcd", 32'(bcd), 32'h000);
        check("midrst_no_pending", 32'(load_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
